// File: rtl/l1_trig_pkg.sv
// Shared types and helpers for the L1 trigger holdoff path.
package l1_trig_pkg;

  localparam int TRIG_WIDTH = 32;
  localparam int SAT_W      = 64;

  typedef enum logic [1:0] {
    DISCARD   = 2'd0,
    DROP_HOLD = 2'd1,
    DROP_FULL = 2'd2,
    ACCEPT    = 2'd3
  } trig_class_t;

  // Increment that sticks at the all-ones value of a width-bit counter (width <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val, input int width);
    logic [SAT_W-1:0] max_v;
    max_v = (width >= SAT_W) ? {SAT_W{1'b1}} : ((64'd1 << width) - 64'd1);
    if (val >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/trig_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output stage.
module trig_fwft_fifo
  import l1_trig_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = TRIG_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_din,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_dvalid,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [WIDTH-1:0]      r_out_data;
  logic                  r_out_valid;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_mem_empty;
  logic w_from_mem;
  logic w_bypass;
  logic w_mem_wr;

  // Occupancy counts the output register too, so full is exactly count == DEPTH.
  assign w_full      = r_count[DEPTH_LOG2];
  assign w_push      = i_push & ~w_full;
  assign w_pop       = i_pop & r_out_valid;
  assign w_load      = ~r_out_valid | w_pop;
  assign w_mem_empty = (r_count == {{DEPTH_LOG2{1'b0}}, r_out_valid});
  assign w_from_mem  = w_load & ~w_mem_empty;
  assign w_bypass    = w_load & w_mem_empty & w_push;
  assign w_mem_wr    = w_push & ~w_bypass;

  // Storage array write port.
  always_ff @(posedge i_clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers, occupancy and output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr    <= {DEPTH_LOG2{1'b0}};
      r_count     <= {(DEPTH_LOG2+1){1'b0}};
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
      if (w_from_mem) begin
        r_out_data  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end else if (w_bypass) begin
        r_out_data  <= i_din;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr;
      end else if (w_load) begin
        r_out_data  <= r_out_data;
        r_out_valid <= 1'b0;
        r_rd_ptr    <= r_rd_ptr;
      end else begin
        r_out_data  <= r_out_data;
        r_out_valid <= r_out_valid;
        r_rd_ptr    <= r_rd_ptr;
      end
    end
  end

  assign o_dout   = r_out_data;
  assign o_dvalid = r_out_valid;
  assign o_full   = w_full;
  assign o_count  = r_count;

endmodule

// File: rtl/l1_trig_holdoff.sv
// Trigger dead-time filter: classifies each input word, buffers accepted ones
// in a FWFT FIFO and keeps saturating accept/drop counters.
module l1_trig_holdoff
  import l1_trig_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int HOLDOFF_BITS    = 16,
  parameter int CNT_BITS        = 32
) (
  input  logic                       ifclk,
  input  logic                       ifclk_rstn,
  input  logic [TRIG_WIDTH-1:0]      s_trig_tdata,
  input  logic                       s_trig_tvalid,
  output logic                       s_trig_tready,
  output logic [TRIG_WIDTH-1:0]      m_trig_tdata,
  output logic                       m_trig_tvalid,
  input  logic                       m_trig_tready,
  input  logic                       run_i,
  input  logic [HOLDOFF_BITS-1:0]    holdoff_i,
  input  logic                       cnt_clr_i,
  output logic [CNT_BITS-1:0]        accept_cnt_o,
  output logic [CNT_BITS-1:0]        drop_cnt_o,
  output logic                       overflow_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count_o
);

  logic                    r_tready;
  logic [HOLDOFF_BITS-1:0] r_hold_cnt;
  logic [CNT_BITS-1:0]     r_accept_cnt;
  logic [CNT_BITS-1:0]     r_drop_cnt;
  logic                    r_overflow;

  logic        w_hs;
  logic        w_full;
  trig_class_t w_class;
  logic        w_accept;
  logic        w_drop;
  logic        w_drop_full;

  assign w_hs = s_trig_tvalid & r_tready;

  // Classify the current handshake; no handshake behaves like a discard.
  always_comb begin
    w_class = DISCARD;
    if (!w_hs) begin
      w_class = DISCARD;
    end else if (!run_i) begin
      w_class = DISCARD;
    end else if (r_hold_cnt != {HOLDOFF_BITS{1'b0}}) begin
      w_class = DROP_HOLD;
    end else if (w_full) begin
      w_class = DROP_FULL;
    end else begin
      w_class = ACCEPT;
    end
  end

  // Decode the class into the individual actions.
  always_comb begin
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_drop_full = 1'b0;
    case (w_class)
      ACCEPT:    w_accept = 1'b1;
      DROP_HOLD: w_drop   = 1'b1;
      DROP_FULL: begin
        w_drop      = 1'b1;
        w_drop_full = 1'b1;
      end
      default: begin
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_drop_full = 1'b0;
      end
    endcase
  end

  // Ready, dead-time counter, statistics; clear beats any same-cycle event.
  always_ff @(posedge ifclk or negedge ifclk_rstn) begin
    if (!ifclk_rstn) begin
      r_tready     <= 1'b0;
      r_hold_cnt   <= {HOLDOFF_BITS{1'b0}};
      r_accept_cnt <= {CNT_BITS{1'b0}};
      r_drop_cnt   <= {CNT_BITS{1'b0}};
      r_overflow   <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      if (w_accept) begin
        r_hold_cnt <= holdoff_i;
      end else if (r_hold_cnt != {HOLDOFF_BITS{1'b0}}) begin
        r_hold_cnt <= r_hold_cnt - {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};
      end else begin
        r_hold_cnt <= r_hold_cnt;
      end
      if (cnt_clr_i) begin
        r_accept_cnt <= {CNT_BITS{1'b0}};
        r_drop_cnt   <= {CNT_BITS{1'b0}};
        r_overflow   <= 1'b0;
      end else begin
        r_accept_cnt <= w_accept ? CNT_BITS'(sat_inc(SAT_W'(r_accept_cnt), CNT_BITS)) : r_accept_cnt;
        r_drop_cnt   <= w_drop   ? CNT_BITS'(sat_inc(SAT_W'(r_drop_cnt), CNT_BITS))   : r_drop_cnt;
        r_overflow   <= r_overflow | w_drop_full;
      end
    end
  end

  trig_fwft_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (TRIG_WIDTH)
  ) u_fifo (
    .i_clk    (ifclk),
    .i_rst_n  (ifclk_rstn),
    .i_push   (w_accept),
    .i_din    (s_trig_tdata),
    .i_pop    (m_trig_tready),
    .o_dout   (m_trig_tdata),
    .o_dvalid (m_trig_tvalid),
    .o_full   (w_full),
    .o_count  (fifo_count_o)
  );

  assign s_trig_tready = r_tready;
  assign accept_cnt_o  = r_accept_cnt;
  assign drop_cnt_o    = r_drop_cnt;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_l1_trig_holdoff.sv
// Scoreboard bench for l1_trig_holdoff: expected words queued at issue, popped by an output monitor.
module tb_l1_trig_holdoff;

  logic        ifclk;
  logic        ifclk_rstn;
  logic [31:0] s_trig_tdata;
  logic        s_trig_tvalid;
  logic        s_trig_tready;
  logic [31:0] m_trig_tdata;
  logic        m_trig_tvalid;
  logic        m_trig_tready;
  logic        run_i;
  logic [15:0] holdoff_i;
  logic        cnt_clr_i;
  logic [31:0] accept_cnt_o;
  logic [31:0] drop_cnt_o;
  logic        overflow_o;
  logic [4:0]  fifo_count_o;

  // Narrow-counter instance sharing the stimulus, used to observe saturation.
  logic        sat_tready;
  logic [31:0] sat_tdata;
  logic        sat_tvalid;
  logic [2:0]  sat_acc;
  logic [2:0]  sat_drop;
  logic        sat_ovf;
  logic [4:0]  sat_fcnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_exp;

  l1_trig_holdoff u_dut (
    .ifclk         (ifclk),
    .ifclk_rstn    (ifclk_rstn),
    .s_trig_tdata  (s_trig_tdata),
    .s_trig_tvalid (s_trig_tvalid),
    .s_trig_tready (s_trig_tready),
    .m_trig_tdata  (m_trig_tdata),
    .m_trig_tvalid (m_trig_tvalid),
    .m_trig_tready (m_trig_tready),
    .run_i         (run_i),
    .holdoff_i     (holdoff_i),
    .cnt_clr_i     (cnt_clr_i),
    .accept_cnt_o  (accept_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
    .overflow_o    (overflow_o),
    .fifo_count_o  (fifo_count_o)
  );

  l1_trig_holdoff #(.CNT_BITS(3)) u_dut_sat (
    .ifclk         (ifclk),
    .ifclk_rstn    (ifclk_rstn),
    .s_trig_tdata  (s_trig_tdata),
    .s_trig_tvalid (s_trig_tvalid),
    .s_trig_tready (sat_tready),
    .m_trig_tdata  (sat_tdata),
    .m_trig_tvalid (sat_tvalid),
    .m_trig_tready (m_trig_tready),
    .run_i         (run_i),
    .holdoff_i     (holdoff_i),
    .cnt_clr_i     (cnt_clr_i),
    .accept_cnt_o  (sat_acc),
    .drop_cnt_o    (sat_drop),
    .overflow_o    (sat_ovf),
    .fifo_count_o  (sat_fcnt)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit exp_acc);
    s_trig_tdata  = d;
    s_trig_tvalid = 1'b1;
    if (exp_acc) sb_q.push_back(d);
    tick();
    s_trig_tvalid = 1'b0;
  endtask

  task automatic clear_counters();
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
  endtask

  // Output monitor: every output handshake must match the oldest expected word.
  always @(negedge ifclk) begin
    if (ifclk_rstn && m_trig_tvalid && m_trig_tready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_extra: actual=%0h required=no word", m_trig_tdata);
      end else begin
        mon_exp = sb_q.pop_front();
        check("out_word", {32'd0, m_trig_tdata}, {32'd0, mon_exp});
      end
    end
  end

  initial begin
    ifclk_rstn    = 1'b1;
    s_trig_tdata  = 32'd0;
    s_trig_tvalid = 1'b0;
    m_trig_tready = 1'b1;
    run_i         = 1'b0;
    holdoff_i     = 16'd0;
    cnt_clr_i     = 1'b0;
    #1 ifclk_rstn = 1'b0;
    #2;
    check("rst_tready", {63'd0, s_trig_tready}, 64'd0);
    check("rst_tvalid", {63'd0, m_trig_tvalid}, 64'd0);
    check("rst_tdata",  {32'd0, m_trig_tdata}, 64'd0);
    check("rst_fcnt",   {59'd0, fifo_count_o}, 64'd0);
    check("rst_acc",    {32'd0, accept_cnt_o}, 64'd0);
    #19 ifclk_rstn = 1'b1;
    tick();
    check("tready_up", {63'd0, s_trig_tready}, 64'd1);

    // Holdoff spacing: H=4 over 20 consecutive triggers.
    run_i     = 1'b1;
    holdoff_i = 16'd4;
    for (int i = 0; i < 20; i++) send(32'h200 + 32'(i), (i % 5) == 0);
    for (int i = 0; i < 6; i++) tick();
    check("h4_acc",      {32'd0, accept_cnt_o}, 64'd4);
    check("h4_drop",     {32'd0, drop_cnt_o}, 64'd16);
    check("h4_ovf",      {63'd0, overflow_o}, 64'd0);
    check("sat_drop",    {61'd0, sat_drop}, 64'd7);
    check("sat_acc_h4",  {61'd0, sat_acc}, 64'd4);

    // Zero holdoff: back-to-back accepts, one-cycle latency, one word per cycle.
    clear_counters();
    check("clr_acc", {32'd0, accept_cnt_o}, 64'd0);
    holdoff_i = 16'd0;
    for (int i = 0; i < 8; i++) begin
      send(32'hA0 + 32'(i), 1'b1);
      check("lat_valid", {63'd0, m_trig_tvalid}, 64'd1);
      check("lat_data",  {32'd0, m_trig_tdata}, {32'd0, 32'hA0 + 32'(i)});
    end
    for (int i = 0; i < 3; i++) tick();
    check("h0_acc",  {32'd0, accept_cnt_o}, 64'd8);
    check("h0_drop", {32'd0, drop_cnt_o}, 64'd0);
    check("h0_fcnt", {59'd0, fifo_count_o}, 64'd0);

    // FIFO full with output stalled.
    clear_counters();
    m_trig_tready = 1'b0;
    for (int i = 0; i < 20; i++) send(32'hC00 + 32'(i), i < 16);
    check("full_fcnt",  {59'd0, fifo_count_o}, 64'd16);
    check("full_acc",   {32'd0, accept_cnt_o}, 64'd16);
    check("full_drop",  {32'd0, drop_cnt_o}, 64'd4);
    check("full_ovf",   {63'd0, overflow_o}, 64'd1);
    check("full_hold",  {32'd0, m_trig_tdata}, {32'd0, 32'hC00});
    check("full_valid", {63'd0, m_trig_tvalid}, 64'd1);
    check("sat_acc",    {61'd0, sat_acc}, 64'd7);

    // Push coincident with pop while full is dropped.
    m_trig_tready = 1'b1;
    send(32'hDEAD, 1'b0);
    check("fullpop_drop", {32'd0, drop_cnt_o}, 64'd5);
    check("fullpop_fcnt", {59'd0, fifo_count_o}, 64'd15);
    for (int i = 0; i < 18; i++) tick();
    check("drain_fcnt", {59'd0, fifo_count_o}, 64'd0);
    check("drain_ovf",  {63'd0, overflow_o}, 64'd1);

    // Clear wins over a same-cycle accept; run_i=0 discards but holdoff still counts down.
    clear_counters();
    check("clr_ovf", {63'd0, overflow_o}, 64'd0);
    cnt_clr_i = 1'b1;
    send(32'hE0, 1'b1);
    cnt_clr_i = 1'b0;
    check("clr_vs_acc", {32'd0, accept_cnt_o}, 64'd0);
    holdoff_i = 16'd3;
    send(32'hF0, 1'b1);
    run_i = 1'b0;
    holdoff_i = 16'd9;
    for (int i = 1; i < 4; i++) send(32'hF0 + 32'(i), 1'b0);
    check("run0_acc",  {32'd0, accept_cnt_o}, 64'd1);
    check("run0_drop", {32'd0, drop_cnt_o}, 64'd0);
    run_i = 1'b1;
    send(32'hF4, 1'b1);
    check("hold_exp_acc",  {32'd0, accept_cnt_o}, 64'd2);
    check("hold_exp_drop", {32'd0, drop_cnt_o}, 64'd0);
    send(32'hF5, 1'b0);
    check("hold_new_drop", {32'd0, drop_cnt_o}, 64'd1);
    for (int i = 0; i < 12; i++) tick();

    // Asynchronous reset with three words buffered.
    m_trig_tready = 1'b0;
    holdoff_i     = 16'd0;
    for (int i = 0; i < 3; i++) send(32'h600 + 32'(i), 1'b1);
    check("pre_rst_fcnt", {59'd0, fifo_count_o}, 64'd3);
    #2 ifclk_rstn = 1'b0;
    #1;
    check("arst_tvalid", {63'd0, m_trig_tvalid}, 64'd0);
    check("arst_tdata",  {32'd0, m_trig_tdata}, 64'd0);
    check("arst_fcnt",   {59'd0, fifo_count_o}, 64'd0);
    check("arst_acc",    {32'd0, accept_cnt_o}, 64'd0);
    check("arst_drop",   {32'd0, drop_cnt_o}, 64'd0);
    check("arst_tready", {63'd0, s_trig_tready}, 64'd0);
    sb_q.delete();
    m_trig_tready = 1'b1;
    ifclk_rstn    = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_valid", {63'd0, m_trig_tvalid}, 64'd0);
    check("post_rst_tready", {63'd0, s_trig_tready}, 64'd1);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
